// File: rtl/button_conditioner.sv
// Conditions one raw button input: 2-flop synchronizer, counter debouncer and a
// press FSM that emits a one-cycle pulse per press plus optional auto-repeat pulses.
module button_conditioner #(
  parameter int CLK_FREQ        = 100_000_000,
  parameter int DEBOUNCE_MS     = 10,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100,
  parameter int REPEAT_EN       = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic pulse,
  output logic held
);

  localparam int DB_CYC    = CLK_FREQ / 1000 * DEBOUNCE_MS;
  localparam int DELAY_CYC = CLK_FREQ / 1000 * REPEAT_DELAY_MS;
  localparam int RATE_CYC  = CLK_FREQ / 1000 * REPEAT_RATE_MS;
  localparam int MAX_AB    = (DB_CYC > DELAY_CYC) ? DB_CYC : DELAY_CYC;
  localparam int MAX_CYC   = (MAX_AB > RATE_CYC) ? MAX_AB : RATE_CYC;
  localparam int CW        = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_CYC);
  localparam logic [CW-1:0] DB_M1    = CW'(DB_CYC - 1);
  localparam logic [CW-1:0] DELAY_M1 = CW'(DELAY_CYC - 1);
  localparam logic [CW-1:0] RATE_M1  = CW'(RATE_CYC - 1);

  if (DB_CYC < 1 || DELAY_CYC < 1 || RATE_CYC < 1) begin : g_bad_timing
    $error("button_conditioner: every derived cycle count must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

  logic          sync1_q, sync1_d;
  logic          sync_q, sync_d;
  logic          level_q, level_d;
  logic [CW-1:0] db_cnt_q, db_cnt_d;
  state_t        state_q, state_d;
  logic [CW-1:0] rpt_cnt_q, rpt_cnt_d;
  logic          pulse_q, pulse_d;
  logic          held_q, held_d;

  // Synchronizer and debouncer.
  always_comb begin
    sync1_d  = btn_raw;
    sync_d   = sync1_q;
    level_d  = level_q;
    db_cnt_d = '0;
    if (sync_q != level_q) begin
      if (db_cnt_q == DB_M1) begin
        level_d  = ~level_q;
        db_cnt_d = '0;
      end else begin
        db_cnt_d = (db_cnt_q == CNT_MAX) ? db_cnt_q : db_cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync_q   <= 1'b0;
      level_q  <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync_q   <= sync_d;
      level_q  <= level_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  // FSM state register, including the registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      rpt_cnt_q <= '0;
      pulse_q   <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rpt_cnt_q <= rpt_cnt_d;
      pulse_q   <= pulse_d;
      held_q    <= held_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (level_q) state_d = HOLD;
      HOLD: begin
        if (!level_q) state_d = IDLE;
        else if (REPEAT_EN != 0 && rpt_cnt_q == DELAY_M1) state_d = REPEAT;
      end
      REPEAT:  if (!level_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Release takes priority over a repeat deadline: every pulse requires level_q.
  always_comb begin
    pulse_d   = 1'b0;
    rpt_cnt_d = rpt_cnt_q;
    held_d    = (state_d == REPEAT);
    case (state_q)
      IDLE: begin
        if (level_q) begin
          pulse_d   = 1'b1;
          rpt_cnt_d = '0;
        end
      end
      HOLD: begin
        if (level_q) begin
          if (REPEAT_EN != 0 && rpt_cnt_q == DELAY_M1) begin
            pulse_d   = 1'b1;
            rpt_cnt_d = '0;
          end else begin
            rpt_cnt_d = (rpt_cnt_q == CNT_MAX) ? rpt_cnt_q : rpt_cnt_q + CW'(1);
          end
        end
      end
      REPEAT: begin
        if (level_q) begin
          if (rpt_cnt_q == RATE_M1) begin
            pulse_d   = 1'b1;
            rpt_cnt_d = '0;
          end else begin
            rpt_cnt_d = (rpt_cnt_q == CNT_MAX) ? rpt_cnt_q : rpt_cnt_q + CW'(1);
          end
        end
      end
      default: ;
    endcase
  end

  assign level = level_q;
  assign pulse = pulse_q;
  assign held  = held_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: a timing model derived from press age checks every
// cycle, and per-test pulse schedules are pinned against hand-computed cycle lists.
module tb_button_conditioner;

  localparam int DB    = 4;
  localparam int DELAY = 20;
  localparam int RATE  = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_raw = 1'b0;
  logic level, pulse, held;
  logic level_nr, pulse_nr, held_nr;

  int vectors = 0;
  int miscompares = 0;

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;

  button_conditioner #(
    .CLK_FREQ(1000), .DEBOUNCE_MS(4), .REPEAT_DELAY_MS(20),
    .REPEAT_RATE_MS(5), .REPEAT_EN(1)
  ) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw),
    .level(level), .pulse(pulse), .held(held)
  );

  button_conditioner #(
    .CLK_FREQ(1000), .DEBOUNCE_MS(4), .REPEAT_DELAY_MS(20),
    .REPEAT_RATE_MS(5), .REPEAT_EN(0)
  ) dut_nr (
    .clk(clk), .reset(reset), .btn_raw(btn_raw),
    .level(level_nr), .pulse(pulse_nr), .held(held_nr)
  );

  // ---------------- behavioural model ----------------
  // level flips after DB consecutive cycles of disagreement with the 2-cycle-delayed
  // input; pulses are scheduled purely from the age of the current press.
  int cyc = 0;
  logic m_s1 = 0, m_s2 = 0, m_lvl = 0;
  int m_run = 0, m_rise = -1000;
  logic m_pulse = 0, m_pulse_nr = 0, m_held = 0, m_valid = 0;

  always @(posedge clk) begin
    int age;
    cyc++;
    if (reset) begin
      m_s1 = 0; m_s2 = 0; m_lvl = 0; m_run = 0; m_rise = -1000;
      m_pulse = 0; m_pulse_nr = 0; m_held = 0; m_valid = 1;
    end else begin
      age = cyc - m_rise;
      if (m_lvl) begin
        m_pulse    = (age == 1) || ((age - 1) >= DELAY && ((age - 1 - DELAY) % RATE) == 0);
        m_pulse_nr = (age == 1);
        m_held     = (age - 1) >= DELAY;
      end else begin
        m_pulse = 0; m_pulse_nr = 0; m_held = 0;
      end
      if (m_s2 != m_lvl) begin
        m_run++;
        if (m_run == DB) begin
          m_lvl = ~m_lvl;
          m_run = 0;
          if (m_lvl) m_rise = cyc;
        end
      end else begin
        m_run = 0;
      end
      m_s2 = m_s1;
      m_s1 = btn_raw;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check_bit(input string name, input logic got, input logic exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%b expected=%b", name, cyc, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      check_bit("level", level, m_lvl);
      check_bit("pulse", pulse, m_pulse);
      check_bit("held", held, m_held);
      check_bit("level_nr", level_nr, m_lvl);
      check_bit("pulse_nr", pulse_nr, m_pulse_nr);
      check_bit("held_nr", held_nr, 1'b0);
    end
  end

  // Pulse logs, in cycles relative to the current test's stimulus edge.
  int t0 = 0;
  int held_first = -1;
  logic [15:0] log_q[$];
  logic [15:0] log_nr_q[$];
  logic [15:0] exp_q[$];

  always @(negedge clk) begin
    if (pulse === 1'b1)    log_q.push_back(16'(cyc - t0));
    if (pulse_nr === 1'b1) log_nr_q.push_back(16'(cyc - t0));
    if (held === 1'b1 && held_first < 0) held_first = cyc - t0;
  end

  task automatic check_log(input string name, input logic [15:0] got[$]);
    int bad;
    bad = (got.size() != exp_q.size());
    for (int i = 0; i < got.size() && !bad; i++) if (got[i] != exp_q[i]) bad = 1;
    vectors++;
    if (bad) begin
      miscompares++;
      $display("FAIL %s got=%p expected=%p", name, got, exp_q);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_test(input logic b);
    btn_raw = b;
    t0 = cyc;
    log_q = {};
    log_nr_q = {};
    held_first = -1;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    tick(2);
    reset = 1'b0;
    tick(3);
    check_bit("reset_level", level, 1'b0);
    check_bit("reset_held", held, 1'b0);

    // 1: clean press held 10 cycles
    start_test(1'b1);
    tick(5);  check_bit("t1_level_c5", level, 1'b0);
    tick(1);  check_bit("t1_level_c6", level, 1'b1);
    tick(4);  btn_raw = 1'b0;
    tick(5);  check_bit("t1_rel_c5", level, 1'b1);
    tick(1);  check_bit("t1_rel_c6", level, 1'b0);
    tick(10);
    exp_q = {16'd7};
    check_log("t1_pulses", log_q);
    check_log("t1_pulses_nr", log_nr_q);
    vectors++;
    if (held_first != -1) begin
      miscompares++;
      $display("FAIL t1_held got=%0d expected=-1", held_first);
    end

    // 2: bounce every 2 cycles, final rising edge at cycle 12
    start_test(1'b0);
    for (int i = 0; i < 6; i++) begin
      btn_raw = ~btn_raw;
      tick(2);
    end
    btn_raw = 1'b1;
    tick(18);
    btn_raw = 1'b0;
    tick(15);
    exp_q = {16'd19};
    check_log("t2_pulses", log_q);

    // 3: press held 60 cycles
    start_test(1'b1);
    tick(60);
    btn_raw = 1'b0;
    tick(20);
    exp_q = {16'd7, 16'd27, 16'd32, 16'd37, 16'd42, 16'd47, 16'd52, 16'd57, 16'd62};
    check_log("t3_pulses", log_q);
    exp_q = {16'd7};
    check_log("t3_pulses_nr", log_nr_q);
    vectors++;
    if (held_first != 27) begin
      miscompares++;
      $display("FAIL t3_held_rise got=%0d expected=27", held_first);
    end

    // 4: 3-cycle glitch low while repeating
    start_test(1'b1);
    tick(30);
    btn_raw = 1'b0;
    tick(3);
    btn_raw = 1'b1;
    tick(17);
    btn_raw = 1'b0;
    tick(20);
    exp_q = {16'd7, 16'd27, 16'd32, 16'd37, 16'd42, 16'd47, 16'd52};
    check_log("t4_pulses", log_q);

    // 5: one-cycle reset during REPEAT with the button still held
    start_test(1'b1);
    tick(30);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check_bit("t5_rst_level", level, 1'b0);
    check_bit("t5_rst_pulse", pulse, 1'b0);
    check_bit("t5_rst_held", held, 1'b0);
    tick(30);
    btn_raw = 1'b0;
    tick(20);
    exp_q = {16'd7, 16'd27, 16'd38, 16'd58, 16'd63};
    check_log("t5_pulses", log_q);

    // 6: 100-cycle hold on the non-repeating instance
    start_test(1'b1);
    tick(100);
    btn_raw = 1'b0;
    tick(20);
    exp_q = {16'd7};
    check_log("t6_pulses_nr", log_nr_q);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
